deinterleaver_scheduler: RTL

- Per-frame sequencer for the receive deinterleaver.
- Gates the coded-bit stream into the deinterleaver one OFDM symbol at a time: the SIGNAL symbol first, then N_SYM DATA symbols.
- Derives N_CBPS and N_SYM from the decoded SIGNAL field (RATE, LENGTH) returned by the downstream decoder.
- Sits between the demapper output and the deinterleaver; owns the deinterleaver start/size/done handshake.

---
 rtl/deinterleaver_scheduler_pkg.sv | 55 +++++
 rtl/deinterleaver_scheduler_nsym_calc.sv | 36 +++
 rtl/deinterleaver_scheduler.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/deinterleaver_scheduler_pkg.sv
// Shared definitions for the receive deinterleaver scheduler:
// SIGNAL/DATA constants, RATE codes, rate lookup and FSM state encoding.
package deinterleaver_scheduler_pkg;

  localparam int unsigned SIG_CBPS     = 48;
  localparam int unsigned SERVICE_TAIL = 22;

  localparam logic [3:0] RATE_6M  = 4'b1101;
  localparam logic [3:0] RATE_9M  = 4'b1111;
  localparam logic [3:0] RATE_12M = 4'b0101;
  localparam logic [3:0] RATE_18M = 4'b0111;
  localparam logic [3:0] RATE_24M = 4'b1001;
  localparam logic [3:0] RATE_36M = 4'b1011;
  localparam logic [3:0] RATE_48M = 4'b0001;
  localparam logic [3:0] RATE_54M = 4'b0011;

  typedef struct packed {
    logic       valid;
    logic [8:0] cbps;
    logic [7:0] dbps;
  } rate_info_t;

  // Map RATE bits R1..R4 to coded/data bits per OFDM symbol.
  function automatic rate_info_t rate_lookup(input logic [3:0] rate);
    rate_info_t r;
    r       = '0;
    r.valid = 1'b1;
    case (rate)
      RATE_6M:  begin r.cbps = 9'd48;  r.dbps = 8'd24;  end
      RATE_9M:  begin r.cbps = 9'd48;  r.dbps = 8'd36;  end
      RATE_12M: begin r.cbps = 9'd96;  r.dbps = 8'd48;  end
      RATE_18M: begin r.cbps = 9'd96;  r.dbps = 8'd72;  end
      RATE_24M: begin r.cbps = 9'd192; r.dbps = 8'd96;  end
      RATE_36M: begin r.cbps = 9'd192; r.dbps = 8'd144; end
      RATE_48M: begin r.cbps = 9'd288; r.dbps = 8'd192; end
      RATE_54M: begin r.cbps = 9'd288; r.dbps = 8'd216; end
      default:  r.valid = 1'b0;
    endcase
    return r;
  endfunction

  typedef enum logic [9:0] {
    IDLE      = 10'b00_0000_0001,
    SIG_START = 10'b00_0000_0010,
    SIG_FILL  = 10'b00_0000_0100,
    SIG_WAIT  = 10'b00_0000_1000,
    CALC      = 10'b00_0001_0000,
    D_START   = 10'b00_0010_0000,
    D_FILL    = 10'b00_0100_0000,
    D_WAIT    = 10'b00_1000_0000,
    DONE      = 10'b01_0000_0000,
    ERR       = 10'b10_0000_0000
  } state_t;

endpackage

// File: rtl/deinterleaver_scheduler_nsym_calc.sv
// Sequential ceil-divide: counts DATA symbols needed to carry nbits
// at dbps bits per symbol, one symbol per step cycle.
module deinterleaver_scheduler_nsym_calc #(
  parameter int unsigned SYM_W = 11
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             clr,
  input  logic             step,
  input  logic [7:0]       dbps,
  input  logic [15:0]      nbits,
  output logic [SYM_W-1:0] nsym,
  output logic             done
);

  logic [16:0] acc;
  logic [16:0] acc_next;

  // Next accumulator value and exit test for the current step.
  always_comb begin
    acc_next = acc + {9'd0, dbps};
    done     = step & (acc_next >= {1'b0, nbits});
  end

  // Accumulate one symbol's worth of data bits per step; nsym holds after done.
  always_ff @(posedge Clk) begin
    if (Reset || clr) begin
      acc  <= '0;
      nsym <= '0;
    end else if (step) begin
      acc  <= acc_next;
      nsym <= nsym + 1'b1;
    end
  end

endmodule

// File: rtl/deinterleaver_scheduler.sv
// Per-frame sequencer for the receive deinterleaver: gates the SIGNAL
// symbol, then N_SYM DATA symbols, sized from the decoded SIGNAL field.
module deinterleaver_scheduler
  import deinterleaver_scheduler_pkg::*;
#(
  parameter int unsigned LEN_W = 12,
  parameter int unsigned SYM_W = 11
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  input  logic             In_valid,
  input  logic             In_bit,
  output logic             In_ready,
  output logic             Dil_start,
  output logic [8:0]       Dil_size,
  output logic             Dil_data,
  output logic             Dil_we,
  input  logic             Dil_done,
  input  logic             Sig_valid,
  input  logic [3:0]       Sig_rate,
  input  logic [LEN_W-1:0] Sig_length,
  input  logic             Sig_parity_ok,
  output logic [SYM_W-1:0] Sym_count,
  output logic             Busy,
  output logic             Frame_done,
  output logic             Error
);

  state_t           state;
  logic [8:0]       bit_cnt;
  logic [8:0]       n_cbps;
  logic [7:0]       n_dbps;
  logic [15:0]      n_bits;
  logic             done_seen;
  logic             sig_seen;
  logic             accept;
  rate_info_t       sig_info;
  logic             sig_ok;
  logic             calc_clr;
  logic             calc_step;
  logic             calc_done;
  logic [SYM_W-1:0] calc_nsym;

  assign accept   = In_valid & In_ready;
  assign Dil_we   = accept;
  assign Dil_data = In_bit;

  // Decode and validate the SIGNAL field presented by the decoder.
  always_comb begin
    sig_info = rate_lookup(Sig_rate);
    sig_ok   = sig_info.valid && (Sig_length != '0) && Sig_parity_ok;
  end

  // The divider restarts from zero whenever a new SIGNAL field is pending.
  assign calc_clr  = (state == IDLE) || (state == SIG_WAIT);
  assign calc_step = (state == CALC);

  deinterleaver_scheduler_nsym_calc #(.SYM_W(SYM_W)) u_nsym_calc (
    .Clk   (Clk),
    .Reset (Reset),
    .clr   (calc_clr),
    .step  (calc_step),
    .dbps  (n_dbps),
    .nbits (n_bits),
    .nsym  (calc_nsym),
    .done  (calc_done)
  );

  // Frame FSM with registered handshake outputs.
  // Dil_size doubles as the fill limit, so both fill states share one compare.
  always_ff @(posedge Clk) begin
    if (Reset || !En) begin
      state      <= IDLE;
      In_ready   <= 1'b0;
      Dil_start  <= 1'b0;
      Dil_size   <= 9'(SIG_CBPS);
      Sym_count  <= '0;
      Busy       <= 1'b0;
      Frame_done <= 1'b0;
      Error      <= 1'b0;
      bit_cnt    <= '0;
      n_cbps     <= '0;
      n_dbps     <= '0;
      n_bits     <= '0;
      done_seen  <= 1'b0;
      sig_seen   <= 1'b0;
    end else begin
      Dil_start  <= 1'b0;
      Frame_done <= 1'b0;
      case (state)
        IDLE: begin
          state     <= SIG_START;
          Dil_start <= 1'b1;
          Dil_size  <= 9'(SIG_CBPS);
          bit_cnt   <= '0;
          Busy      <= 1'b1;
        end
        SIG_START: begin
          state    <= SIG_FILL;
          In_ready <= 1'b1;
        end
        SIG_FILL: begin
          if (accept) begin
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == Dil_size - 1'b1) begin
              In_ready <= 1'b0;
              state    <= SIG_WAIT;
            end
          end
        end
        SIG_WAIT: begin
          if (Sig_valid && !sig_seen && !sig_ok) begin
            state <= ERR;
            Error <= 1'b1;
          end else begin
            if (Sig_valid && !sig_seen) begin
              sig_seen <= 1'b1;
              n_cbps   <= sig_info.cbps;
              n_dbps   <= sig_info.dbps;
              n_bits   <= 16'({Sig_length, 3'b000}) + 16'(SERVICE_TAIL);
            end
            if (Dil_done)
              done_seen <= 1'b1;
            if ((Sig_valid || sig_seen) && (Dil_done || done_seen))
              state <= CALC;
          end
        end
        CALC: begin
          if (calc_done) begin
            state     <= D_START;
            Dil_start <= 1'b1;
            Dil_size  <= n_cbps;
            bit_cnt   <= '0;
          end
        end
        D_START: begin
          state    <= D_FILL;
          In_ready <= 1'b1;
        end
        D_FILL: begin
          if (accept) begin
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == Dil_size - 1'b1) begin
              In_ready <= 1'b0;
              state    <= D_WAIT;
            end
          end
        end
        D_WAIT: begin
          if (Dil_done) begin
            Sym_count <= Sym_count + 1'b1;
            if ((Sym_count + 1'b1) == calc_nsym) begin
              Frame_done <= 1'b1;
              state      <= DONE;
            end else begin
              state     <= D_START;
              Dil_start <= 1'b1;
              bit_cnt   <= '0;
            end
          end
        end
        DONE: ;
        ERR:  ;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
